// File: rtl/and_gate_pkg.sv
// Shared constants for the and_gate cell: default operand width and high-cycle counter width.
package and_gate_pkg;

    localparam int unsigned DefaultWidth = 1;
    localparam int unsigned DefaultCntW  = 16;

endpackage

// File: rtl/and_gate_if.sv
// Operand/result bundle for and_gate; master drives operands, slave produces results.
interface and_gate_if
    import and_gate_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = DefaultCntW
) ();

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] c_rise;
    logic [CNT_W-1:0] hi_cnt;

    modport master (
        output a,
        output b,
        input  c,
        input  c_q,
        input  c_rise,
        input  hi_cnt
    );

    modport slave (
        input  a,
        input  b,
        output c,
        output c_q,
        output c_rise,
        output hi_cnt
    );

endinterface

// File: rtl/and_gate_sat_counter.sv
// Saturating up-counter: increments on each enabled edge, holds at all-ones, async clear.
module and_gate_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/and_gate.sv
// Bitwise AND with a clocked observation side: registered result, rising strobe and a
// saturating count of cycles where bit 0 of the result is high.
module and_gate
    import and_gate_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = DefaultCntW
) (
    input  logic     clk,
    input  logic     rst_n,
    and_gate_if.slave bus
);

    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] c_d;
    logic [CNT_W-1:0] hi_cnt;

    // Purely combinational path: must not depend on clk or rst_n.
    assign c   = bus.a & bus.b;
    assign c_d = c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
        end else begin
            c_q <= c_d;
        end
    end

    and_gate_sat_counter #(
        .CNT_W (CNT_W)
    ) u_hi_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (c[0]),
        .cnt_o (hi_cnt)
    );

    assign bus.c      = c;
    assign bus.c_q    = c_q;
    assign bus.c_rise = c & ~c_q;
    assign bus.hi_cnt = hi_cnt;

endmodule

// File: tb/tb_and_gate.sv
// Randomised self-checking bench for and_gate: a 1-bit/16-bit-counter instance and a
// 4-bit/3-bit-counter instance share clock and reset, checked against an event-count model.
module tb_and_gate;

    logic clk;
    logic rst_n;
    logic clk_run;

    int checks;
    int errors;

    // Reference model: last sampled result and number of high-bit-0 samples since reset.
    logic       exp_q0;
    int         n0;
    logic [3:0] exp_q1;
    int         n1;

    and_gate_if #(.WIDTH(1), .CNT_W(16)) bus0 ();
    and_gate_if #(.WIDTH(4), .CNT_W(3))  bus1 ();

    and_gate #(
        .WIDTH (1),
        .CNT_W (16)
    ) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    and_gate #(
        .WIDTH (4),
        .CNT_W (3)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = clk_run ? ~clk : 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int max_val);
        return (n > max_val) ? max_val : n;
    endfunction

    task automatic model_clear();
        exp_q0 = 1'b0;
        n0     = 0;
        exp_q1 = 4'b0;
        n1     = 0;
    endtask

    // Starts at a falling edge, ends at the next falling edge.
    task automatic step(input logic a0v, input logic b0v, input logic [3:0] a1v,
                        input logic [3:0] b1v);
        logic       c0;
        logic [3:0] c1;
        logic       r0;
        logic [3:0] r1;
        bus0.a = a0v;
        bus0.b = b0v;
        bus1.a = a1v;
        bus1.b = b1v;
        c0 = a0v & b0v;
        c1 = a1v & b1v;
        r0 = c0 & ~exp_q0;
        r1 = c1 & ~exp_q1;
        #1;
        check("c0", 32'(bus0.c), 32'(c0));
        check("rise0", 32'(bus0.c_rise), 32'(r0));
        check("c1", 32'(bus1.c), 32'(c1));
        check("rise1", 32'(bus1.c_rise), 32'(r1));
        @(posedge clk);
        if (rst_n) begin
            exp_q0 = c0;
            exp_q1 = c1;
            if (c0) n0++;
            if (c1[0]) n1++;
        end
        @(negedge clk);
        check("cq0", 32'(bus0.c_q), 32'(exp_q0));
        check("hi0", 32'(bus0.hi_cnt), 32'(sat(n0, 65535)));
        check("cq1", 32'(bus1.c_q), 32'(exp_q1));
        check("hi1", 32'(bus1.hi_cnt), 32'(sat(n1, 7)));
    endtask

    // Asserts reset between edges, checks immediate clear, releases on the next falling edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_cq0", 32'(bus0.c_q), 32'd0);
        check("ar_hi0", 32'(bus0.hi_cnt), 32'd0);
        check("ar_cq1", 32'(bus1.c_q), 32'd0);
        check("ar_hi1", 32'(bus1.hi_cnt), 32'd0);
        check("ar_c0", 32'(bus0.c), 32'(bus0.a & bus0.b));
        check("ar_c1", 32'(bus1.c), 32'(bus1.a & bus1.b));
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] tt_a;
        logic [1:0] tt_b;
        logic [3:0] tt_c;
        checks  = 0;
        errors  = 0;
        clk     = 1'b0;
        clk_run = 1'b0;
        rst_n   = 1'b0;
        model_clear();

        // Truth table with clock stopped and reset held.
        tt_a = 2'b00;
        tt_b = 2'b00;
        tt_c = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin tt_a = 2'b00; tt_b = 2'b00; end
                1: begin tt_a = 2'b01; tt_b = 2'b00; end
                2: begin tt_a = 2'b01; tt_b = 2'b01; end
                default: begin tt_a = 2'b00; tt_b = 2'b01; end
            endcase
            bus0.a = tt_a[0];
            bus0.b = tt_b[0];
            bus1.a = {tt_a, tt_a};
            bus1.b = {tt_b, tt_b};
            tt_c = {tt_a & tt_b, tt_a & tt_b};
            #10;
            check("tt_c0", 32'(bus0.c), (i == 2) ? 32'd1 : 32'd0);
            check("tt_rise0", 32'(bus0.c_rise), (i == 2) ? 32'd1 : 32'd0);
            check("tt_c1", 32'(bus1.c), 32'(tt_c));
        end

        // Reset values while the clock toggles.
        bus0.a = 1'b1;
        bus0.b = 1'b1;
        bus1.a = 4'hf;
        bus1.b = 4'hf;
        clk_run = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cq0", 32'(bus0.c_q), 32'd0);
        check("rst_hi0", 32'(bus0.hi_cnt), 32'd0);
        check("rst_cq1", 32'(bus1.c_q), 32'd0);
        check("rst_hi1", 32'(bus1.hi_cnt), 32'd0);

        // Release and hold a=b=1: first edge counts, strobe only before edge 1.
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'hf, 4'hf);
        check("hi_five", 32'(bus0.hi_cnt), 32'd5);

        // Narrow counter saturates at 7 and stays there.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'hf, 4'hf);
        check("sat_seven", 32'(bus1.hi_cnt), 32'd7);
        check("wide_ten", 32'(bus0.hi_cnt), 32'd10);

        // Async reset mid-run after four counted edges.
        async_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'hf, 4'hf);
        check("hi_four", 32'(bus0.hi_cnt), 32'd4);
        async_reset();

        // Multi-bit AND.
        step(1'b0, 1'b1, 4'b1100, 4'b1010);
        check("w4_cq", 32'(bus1.c_q), 32'h8);

        // Random operands with occasional asynchronous resets.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
            if ($urandom_range(0, 19) == 0) async_reset();
        end

        // Long high run to push the narrow counter into saturation again.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 4'hf, 4'hf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
